// File: rtl/spi_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// spi_xfer_ctrl
//
// Sequencer in front of a single-byte SPI engine. It takes one request
// (slave index, byte count, clock divisor, mode), frames the transfer with
// that slave's active-low chip select, feeds TX bytes from a valid/ready
// stream into the engine one at a time, and returns every received byte on
// an RX valid/ready stream. The frame is closed with programmable select
// setup, hold and inter-frame gap times.
//
// Parameters:
//   N_SLAVES  number of chip selects (>= 1)
//   CS_SETUP  cycles with ss_n low before the first byte may start (>= 1)
//   CS_HOLD   cycles with ss_n low after the last byte is consumed (>= 1)
//   CS_GAP    cycles with all ss_n high before the next request (>= 1)
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   req_valid/req_ready           request handshake
//   req_slave/len/dvsr/cpol/cpha  request fields, latched on acceptance
//   tx_valid/tx_ready/tx_data     TX byte stream into the engine
//   rx_valid/rx_ready/rx_data     RX byte stream out of the engine
//   done                          one-cycle pulse at the end of a transaction
//   busy                          high whenever the sequencer is not idle
//   ss_n                          active-low chip selects
//   spi_din/dvsr/cpol/cpha/start  drive the byte engine
//   spi_dout/done_tick/ready      returned by the byte engine
// ---------------------------------------------------------------------------
module spi_xfer_ctrl #(
    parameter int N_SLAVES = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 4,
    localparam int SW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [SW-1:0]       req_slave,
    input  logic [7:0]          req_len,
    input  logic [15:0]         req_dvsr,
    input  logic                req_cpol,
    input  logic                req_cpha,
    input  logic                tx_valid,
    output logic                tx_ready,
    input  logic [7:0]          tx_data,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic [7:0]          rx_data,
    output logic                done,
    output logic                busy,
    output logic [N_SLAVES-1:0] ss_n,
    output logic [7:0]          spi_din,
    output logic [15:0]         spi_dvsr,
    output logic                spi_cpol,
    output logic                spi_cpha,
    output logic                spi_start,
    input  logic [7:0]          spi_dout,
    input  logic                spi_done_tick,
    input  logic                spi_ready
);

    typedef enum logic [3:0] {
        IDLE,
        SETUP,
        WAIT_TX,
        START,
        BUSY,
        RX,
        HOLD,
        GAP,
        DONE
    } state_t;

    state_t        r_state;
    state_t        w_nextState;
    logic [15:0]   r_timer;
    logic [7:0]    r_byteCnt;
    logic [SW-1:0] r_slave;
    logic [15:0]   r_dvsr;
    logic          r_cpol;
    logic          r_cpha;
    logic [7:0]    r_din;
    logic [7:0]    r_rxData;
    logic          w_frameActive;

    // State register plus a shared dwell timer. The timer restarts on every
    // state change, so SETUP, HOLD and GAP each count from zero on entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_timer <= 16'd0;
        end else begin
            r_state <= w_nextState;
            if (r_state != w_nextState) begin
                r_timer <= 16'd0;
            end else begin
                r_timer <= r_timer + 16'd1;
            end
        end
    end

    // Next-state logic. A stalled TX or RX stream simply parks the machine
    // in WAIT_TX or RX with the frame still open.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_nextState = (req_len == 8'd0) ? DONE : SETUP;
                end
            end
            SETUP: begin
                if (r_timer == 16'(CS_SETUP - 1)) begin
                    w_nextState = WAIT_TX;
                end
            end
            WAIT_TX: begin
                if (tx_valid && spi_ready) begin
                    w_nextState = START;
                end
            end
            START: begin
                w_nextState = BUSY;
            end
            BUSY: begin
                if (spi_done_tick) begin
                    w_nextState = RX;
                end
            end
            RX: begin
                if (rx_ready) begin
                    w_nextState = (r_byteCnt == 8'd1) ? HOLD : WAIT_TX;
                end
            end
            HOLD: begin
                if (r_timer == 16'(CS_HOLD - 1)) begin
                    w_nextState = GAP;
                end
            end
            GAP: begin
                if (r_timer == 16'(CS_GAP - 1)) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Outputs decoded purely from the current state. A slave index beyond
    // N_SLAVES matches no select line, so the bytes run with ss_n all high.
    always_comb begin
        req_ready     = (r_state == IDLE);
        tx_ready      = (r_state == WAIT_TX) && spi_ready;
        rx_valid      = (r_state == RX);
        spi_start     = (r_state == START);
        done          = (r_state == DONE);
        busy          = (r_state != IDLE);
        w_frameActive = (r_state == SETUP) || (r_state == WAIT_TX) ||
                        (r_state == START) || (r_state == BUSY) ||
                        (r_state == RX) || (r_state == HOLD);
        ss_n          = '1;
        if (w_frameActive) begin
            for (int i = 0; i < N_SLAVES; i++) begin
                if (r_slave == SW'(i)) begin
                    ss_n[i] = 1'b0;
                end
            end
        end
    end

    // Datapath: request latches, TX byte register, RX capture and the
    // remaining-byte counter. The engine configuration comes straight from
    // the latches so it stays fixed for the whole transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_slave   <= '0;
            r_byteCnt <= 8'd0;
            r_dvsr    <= 16'd0;
            r_cpol    <= 1'b0;
            r_cpha    <= 1'b0;
            r_din     <= 8'd0;
            r_rxData  <= 8'd0;
        end else begin
            if (r_state == IDLE && req_valid) begin
                r_slave   <= req_slave;
                r_byteCnt <= req_len;
                r_dvsr    <= req_dvsr;
                r_cpol    <= req_cpol;
                r_cpha    <= req_cpha;
            end
            if (tx_valid && tx_ready) begin
                r_din <= tx_data;
            end
            if (r_state == BUSY && spi_done_tick) begin
                r_rxData <= spi_dout;
            end
            if (r_state == RX && rx_ready) begin
                r_byteCnt <= r_byteCnt - 8'd1;
            end
        end
    end

    assign rx_data  = r_rxData;
    assign spi_din  = r_din;
    assign spi_dvsr = r_dvsr;
    assign spi_cpol = r_cpol;
    assign spi_cpha = r_cpha;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_xfer_ctrl
//
// Self-checking bench for spi_xfer_ctrl. A behavioural byte engine in
// loopback (whatever is shifted out comes straight back) stands in for the
// real SPI engine. TX bytes are pushed onto an expected-RX queue when their
// handshake is driven and popped when the RX stream delivers a byte.
//
// N_SLAVES is 5 so that slave index 5 is representable on the 3-bit select
// field while still lying outside the populated range.
//
// Cycle numbering: the cycle observed at a falling edge is the one that ends
// at the next rising edge, i.e. (rising edges so far) + 1. A handshake
// decided at that falling edge completes at that same cycle number.
// ---------------------------------------------------------------------------
module tb_spi_xfer_ctrl;

    localparam int N_SLAVES = 5;
    localparam int SW       = 3;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int CS_GAP   = 4;
    localparam int TIMEOUT  = 5000;

    logic                clk = 1'b0;
    logic                reset;
    logic                req_valid;
    logic                req_ready;
    logic [SW-1:0]       req_slave;
    logic [7:0]          req_len;
    logic [15:0]         req_dvsr;
    logic                req_cpol;
    logic                req_cpha;
    logic                tx_valid;
    logic                tx_ready;
    logic [7:0]          tx_data;
    logic                rx_valid;
    logic                rx_ready;
    logic [7:0]          rx_data;
    logic                done;
    logic                busy;
    logic [N_SLAVES-1:0] ss_n;
    logic [7:0]          spi_din;
    logic [15:0]         spi_dvsr;
    logic                spi_cpol;
    logic                spi_cpha;
    logic                spi_start;
    logic [7:0]          spi_dout;
    logic                spi_done_tick;
    logic                spi_ready;

    spi_xfer_ctrl #(
        .N_SLAVES(N_SLAVES),
        .CS_SETUP(CS_SETUP),
        .CS_HOLD (CS_HOLD),
        .CS_GAP  (CS_GAP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_slave    (req_slave),
        .req_len      (req_len),
        .req_dvsr     (req_dvsr),
        .req_cpol     (req_cpol),
        .req_cpha     (req_cpha),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_data      (tx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_data      (rx_data),
        .done         (done),
        .busy         (busy),
        .ss_n         (ss_n),
        .spi_din      (spi_din),
        .spi_dvsr     (spi_dvsr),
        .spi_cpol     (spi_cpol),
        .spi_cpha     (spi_cpha),
        .spi_start    (spi_start),
        .spi_dout     (spi_dout),
        .spi_done_tick(spi_done_tick),
        .spi_ready    (spi_ready)
    );

    always #5 clk = ~clk;

    // Rising-edge counter used to timestamp events.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int testsRun    = 0;
    int testsFailed = 0;

    // Configuration the current transaction should present to the engine.
    logic [15:0] expDvsr = 16'd0;
    logic        expCpol = 1'b0;
    logic        expCpha = 1'b0;

    // Behavioural loopback byte engine: a byte takes 4*(dvsr+1) cycles and
    // returns exactly what was shifted out. Configuration is checked at
    // every start against what the current request asked for.
    logic        engBusy;
    int          engCnt;
    logic [7:0]  engData;
    int          cfgBad = 0;

    always @(posedge clk) begin
        if (reset) begin
            engBusy       <= 1'b0;
            engCnt        <= 0;
            engData       <= 8'd0;
            spi_done_tick <= 1'b0;
            spi_ready     <= 1'b1;
            spi_dout      <= 8'd0;
        end else begin
            spi_done_tick <= 1'b0;
            if (!engBusy && spi_start) begin
                engBusy   <= 1'b1;
                spi_ready <= 1'b0;
                engData   <= spi_din;
                engCnt    <= 4 * (int'(spi_dvsr) + 1);
                if (spi_dvsr !== expDvsr || spi_cpol !== expCpol || spi_cpha !== expCpha) begin
                    cfgBad <= cfgBad + 1;
                end
            end else if (engBusy) begin
                if (engCnt == 0) begin
                    engBusy       <= 1'b0;
                    spi_ready     <= 1'b1;
                    spi_done_tick <= 1'b1;
                    spi_dout      <= engData;
                end else begin
                    engCnt <= engCnt - 1;
                end
            end
        end
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Results of the most recent transaction.
    logic [7:0] txBytes [8];
    logic [7:0] rxExp [$];
    int accCycle, firstTxReadyCycle, lastRxCycle, riseCycle, doneCycle;
    int startCount, ssBad, stallBad, cfgBase;
    bit doneSeen, aborted;

    // Issue one request and serve its TX/RX streams until done (or until
    // abortAfterStarts bytes have been started and the engine is mid-byte).
    task automatic applyStimulus(input logic [SW-1:0] slave, input logic [7:0] len,
                                 input logic [15:0] dvsr, input logic cpol, input logic cpha,
                                 input int txGap, input int stallByte, input int stallCycles,
                                 input int abortAfterStarts, input logic [N_SLAVES-1:0] framePat);
        int txIdx, rxIdx, gapLeft, stallLeft, budget;
        bit stalling, stallDone, ssRisen;
        logic [7:0] heldData;
        logic [7:0] expByte;

        expDvsr = dvsr;
        expCpol = cpol;
        expCpha = cpha;
        rxExp.delete();
        firstTxReadyCycle = -1;
        lastRxCycle       = -1;
        riseCycle         = -1;
        doneCycle         = -1;
        startCount        = 0;
        ssBad             = 0;
        stallBad          = 0;
        doneSeen          = 0;
        aborted           = 0;

        @(negedge clk);
        cfgBase = cfgBad;
        budget = 0;
        while (!req_ready && budget < TIMEOUT) begin
            @(negedge clk);
            budget++;
        end
        req_valid = 1'b1;
        req_slave = slave;
        req_len   = len;
        req_dvsr  = dvsr;
        req_cpol  = cpol;
        req_cpha  = cpha;
        accCycle  = cyc + 1;
        @(negedge clk);
        // Scramble the request fields so a missing latch shows up.
        req_valid = 1'b0;
        req_len   = 8'hFF;
        req_dvsr  = ~dvsr;
        req_cpol  = ~cpol;
        req_cpha  = ~cpha;

        txIdx     = 0;
        rxIdx     = 0;
        gapLeft   = txGap;
        stalling  = 0;
        stallDone = 0;
        stallLeft = 0;
        ssRisen   = 0;
        heldData  = 8'd0;
        budget    = 0;
        while (!doneSeen && budget < TIMEOUT) begin
            if (done) begin
                doneSeen  = 1;
                doneCycle = cyc + 1;
            end
            if (spi_start) startCount++;
            if (abortAfterStarts > 0 && startCount >= abortAfterStarts && !spi_start) begin
                aborted = 1;
                break;
            end

            if (ssRisen) begin
                if (ss_n !== '1) ssBad++;
            end else if (lastRxCycle >= 0 && ss_n === '1) begin
                ssRisen   = 1;
                riseCycle = cyc + 1;
            end else if (ss_n !== framePat && !doneSeen) begin
                ssBad++;
            end

            if (tx_ready && firstTxReadyCycle < 0) firstTxReadyCycle = cyc + 1;
            if (txIdx < int'(len)) begin
                if (gapLeft > 0) begin
                    tx_valid = 1'b0;
                    gapLeft--;
                end else begin
                    tx_valid = 1'b1;
                    tx_data  = txBytes[txIdx];
                    if (tx_ready) begin
                        rxExp.push_back(txBytes[txIdx]);
                        txIdx++;
                        gapLeft = txGap;
                    end
                end
            end else begin
                tx_valid = 1'b0;
            end

            if (rx_valid && rxIdx == stallByte && !stallDone && stallCycles > 0) begin
                if (!stalling) begin
                    stalling  = 1;
                    stallLeft = stallCycles;
                    heldData  = rx_data;
                end else if (rx_data !== heldData || spi_start || ss_n !== framePat) begin
                    stallBad++;
                end
                rx_ready = 1'b0;
                stallLeft--;
                if (stallLeft == 0) stallDone = 1;
            end else begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    if (rxExp.size() == 0) begin
                        checkOutput("rx_unexpected", 32'(rx_data), 32'hFFFF_FFFF);
                    end else begin
                        expByte = rxExp.pop_front();
                        checkOutput("rx_data", 32'(rx_data), 32'(expByte));
                    end
                    rxIdx++;
                    if (rxIdx == int'(len)) lastRxCycle = cyc + 1;
                end
            end

            @(negedge clk);
            budget++;
        end
        tx_valid = 1'b0;
        rx_ready = 1'b1;

        if (!aborted) begin
            checkOutput("timeout", 32'(doneSeen), 32'd1);
            checkOutput("rx_missing", 32'(rxExp.size()), 32'd0);
            // The cycle after done: pulse is over and a new request is welcome.
            checkOutput("done_one_cycle", 32'(done), 32'd0);
            checkOutput("req_ready_after_done", 32'(req_ready), 32'd1);
        end
    endtask

    task automatic checkCommon(input string name, input int nBytes);
        checkOutput({name, "_starts"}, 32'(startCount), 32'(nBytes));
        checkOutput({name, "_ss_n"}, 32'(ssBad), 32'd0);
        checkOutput({name, "_cfg"}, 32'(cfgBad - cfgBase), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_slave = '0;
        req_len   = 8'd0;
        req_dvsr  = 16'd0;
        req_cpol  = 1'b0;
        req_cpha  = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = 8'd0;
        rx_ready  = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state.
        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_ss_n", 32'(ss_n), 32'h1F);
        checkOutput("rst_busy_done", {30'd0, busy, done}, 32'd0);
        checkOutput("rst_streams", {29'd0, tx_ready, rx_valid, spi_start}, 32'd0);
        checkOutput("rst_data", {16'd0, rx_data, spi_din}, 32'd0);
        checkOutput("rst_cfg", {14'd0, spi_dvsr, spi_cpol, spi_cpha}, 32'd0);

        // Loopback, slave 2, three bytes, mode 0, and frame timing.
        txBytes[0] = 8'h55;
        txBytes[1] = 8'hA3;
        txBytes[2] = 8'h0F;
        applyStimulus(3'd2, 8'd3, 16'd4, 1'b0, 1'b0, 0, -1, 0, 0, 5'b11011);
        checkCommon("loop3", 3);
        checkOutput("loop3_first_tx_ready", 32'(firstTxReadyCycle - accCycle), 32'd3);
        checkOutput("loop3_ss_rise", 32'(riseCycle - lastRxCycle), 32'd3);
        checkOutput("loop3_done_after_rise", 32'(doneCycle - riseCycle), 32'd4);

        // RX backpressure on the first of two bytes.
        txBytes[0] = 8'hC3;
        txBytes[1] = 8'h3C;
        applyStimulus(3'd0, 8'd2, 16'd2, 1'b0, 1'b0, 0, 0, 50, 0, 5'b11110);
        checkCommon("stall", 2);
        checkOutput("stall_hold", 32'(stallBad), 32'd0);

        // TX starvation in all four modes at dvsr 1.
        for (int m = 0; m < 4; m++) begin
            txBytes[0] = 8'($urandom_range(0, 255));
            txBytes[1] = 8'($urandom_range(0, 255));
            applyStimulus(3'd3, 8'd2, 16'd1, m[1], m[0], 20, -1, 0, 0, 5'b10111);
            checkCommon($sformatf("mode%0d", m), 2);
        end

        // Zero-length request: done at once, no select activity.
        applyStimulus(3'd1, 8'd0, 16'd3, 1'b1, 1'b0, 0, -1, 0, 0, 5'b11111);
        checkCommon("len0", 0);
        checkOutput("len0_done_cycle", 32'(doneCycle - accCycle), 32'd1);

        // Out-of-range slave: no select, byte still runs.
        txBytes[0] = 8'h96;
        applyStimulus(3'd5, 8'd1, 16'd1, 1'b0, 1'b1, 0, -1, 0, 0, 5'b11111);
        checkCommon("noslave", 1);

        // Reset while byte 2 of 4 is in flight.
        txBytes[0] = 8'h11;
        txBytes[1] = 8'h22;
        txBytes[2] = 8'h33;
        txBytes[3] = 8'h44;
        applyStimulus(3'd1, 8'd4, 16'd4, 1'b1, 1'b1, 0, -1, 0, 2, 5'b11101);
        checkOutput("abort_reached", 32'(aborted), 32'd1);
        checkOutput("abort_mid_frame", {27'd0, ss_n}, 32'h1D);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort_ss_n", 32'(ss_n), 32'h1F);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_req_ready", 32'(req_ready), 32'd1);
        checkOutput("abort_data", {16'd0, rx_data, spi_din}, 32'd0);

        txBytes[0] = 8'h5A;
        applyStimulus(3'd0, 8'd1, 16'd2, 1'b0, 1'b0, 0, -1, 0, 0, 5'b11110);
        checkCommon("after_reset", 1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
